// File: rtl/host_bus_master.sv
// host_bus_master
//
// Bus initiator for the shared 8-bit CPU bus. It turns a byte-serial host
// command stream into single-cycle bus reads and writes. It is used to load
// memory and peripherals, read back locations, and start or halt the CPU
// through the control module's state register.
//
// Command packets (opcode first):
//   01 WRITE : addr, data          -> one bus write
//   02 READ  : addr                -> one bus read, one response byte
//   03 BURST : addr, N, N x data   -> N writes to addr, addr+1, ... (8-bit wrap)
//   04 START : (none)              -> write {4'h0, START_STATE} to CTRL_STATE_ADDR
//   05 HALT  : (none)              -> write {4'h0, HALT_STATE}  to CTRL_STATE_ADDR
//   other    : byte consumed, cmd_err pulses for one cycle
//
// Ports:
//   clk, rst_n            clock (posedge) and async active-low reset
//   cmd_valid/cmd_ready   host byte handshake, cmd_data carries the byte
//   rsp_valid/rsp_ready   read-response handshake, rsp_data carries the byte
//   bus_addr/bus_data     bus address and write data (bus_data is 0 unless writing)
//   bus_read/bus_write    one-cycle strobes, never both high
//   bus_rdata             read data from the addressed slave, RD_LAT cycles after bus_read
//   cmd_err               one-cycle pulse on an unknown opcode
//   busy                  high while the FSM is outside IDLE
//
// All outputs are registered.

module host_bus_master #(
    parameter logic [7:0]  CTRL_STATE_ADDR = 8'hFF,
    parameter logic [3:0]  START_STATE     = 4'h2,
    parameter logic [3:0]  HALT_STATE      = 4'h0,
    parameter int unsigned RD_LAT          = 1      // legal range 1..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic [7:0] bus_addr,
    output logic       bus_read,
    output logic       bus_write,
    output logic [7:0] bus_data,
    input  logic [7:0] bus_rdata,
    output logic       cmd_err,
    output logic       busy
);

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_READ  = 8'h02;
    localparam logic [7:0] OPC_BURST = 8'h03;
    localparam logic [7:0] OPC_START = 8'h04;
    localparam logic [7:0] OPC_HALT  = 8'h05;

    // The RD_WAIT cycle counter counts down from RD_LAT-1 to 0.
    // The capture happens in the cycle where it reads 0.
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CNT,
        S_BURST_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_RSP
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_BURST,
        OP_CTRL
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] lat_q, lat_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic       bus_read_q, bus_read_d;
    logic       bus_write_q, bus_write_d;
    logic [7:0] bus_data_q, bus_data_d;
    logic       cmd_err_q, cmd_err_d;
    logic       busy_q, busy_d;

    logic       cmd_fire;

    assign cmd_fire = cmd_valid && cmd_ready_q;

    always_comb begin
        // NOTE: every signal assigned below gets a default first. Without one,
        // any path through the case that skips the signal would infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        bus_addr_d  = bus_addr_q;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        bus_data_d  = 8'h00;
        cmd_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    unique case (cmd_data)
                        OPC_WRITE: begin
                            op_d    = OP_WRITE;
                            state_d = S_GET_ADDR;
                        end
                        OPC_READ: begin
                            op_d    = OP_READ;
                            state_d = S_GET_ADDR;
                        end
                        OPC_BURST: begin
                            op_d    = OP_BURST;
                            state_d = S_GET_ADDR;
                        end
                        OPC_START, OPC_HALT: begin
                            op_d        = OP_CTRL;
                            state_d     = S_BUS_WR;
                            bus_write_d = 1'b1;
                            bus_addr_d  = CTRL_STATE_ADDR;
                            bus_data_d  = {4'h0, (cmd_data == OPC_START) ? START_STATE : HALT_STATE};
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end

            S_GET_ADDR: begin
                if (cmd_fire) begin
                    addr_d = cmd_data;
                    unique case (op_q)
                        OP_WRITE: state_d = S_GET_DATA;
                        OP_READ: begin
                            state_d    = S_BUS_RD;
                            bus_read_d = 1'b1;
                            bus_addr_d = cmd_data;
                        end
                        default: state_d = S_GET_CNT;
                    endcase
                end
            end

            S_GET_DATA, S_BURST_DATA: begin
                if (cmd_fire) begin
                    state_d     = S_BUS_WR;
                    bus_write_d = 1'b1;
                    bus_addr_d  = addr_q;
                    bus_data_d  = cmd_data;
                end
            end

            S_GET_CNT: begin
                if (cmd_fire) begin
                    cnt_d   = cmd_data;
                    state_d = (cmd_data == 8'h00) ? S_IDLE : S_BURST_DATA;
                end
            end

            S_BUS_WR: begin
                // The strobe is already on the bus this cycle. Only a burst
                // has bookkeeping to do: advance the address and loop while
                // data bytes remain.
                state_d = S_IDLE;
                if (op_q == OP_BURST) begin
                    cnt_d  = cnt_q - 8'd1;
                    addr_d = addr_q + 8'd1;
                    if (cnt_q != 8'd1) begin
                        state_d = S_BURST_DATA;
                    end
                end
            end

            S_BUS_RD: begin
                lat_d   = LAT_INIT;
                state_d = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (lat_q == 2'd0) begin
                    rsp_data_d  = bus_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end

            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Host-side ready and busy both track the next state, so they are
        // correct in the same cycle the FSM arrives there.
        cmd_ready_d = (state_d == S_IDLE)     || (state_d == S_GET_ADDR) ||
                      (state_d == S_GET_DATA) || (state_d == S_GET_CNT)  ||
                      (state_d == S_BURST_DATA);
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            addr_q      <= 8'h00;
            cnt_q       <= 8'h00;
            lat_q       <= 2'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            bus_addr_q  <= 8'h00;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_data_q  <= 8'h00;
            cmd_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_data_q  <= bus_data_d;
            cmd_err_q   <= cmd_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign bus_addr  = bus_addr_q;
    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign bus_data  = bus_data_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = busy_q;

endmodule
